// File: rtl/ovi_issue_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ovi_issue_sequencer
//  Description : Vector issue/dispatch/completion sequencer between a core and
//                a VPU: credit-gated issue, in-order dispatch, out-of-order
//                completion over a circular scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module ovi_issue_sequencer #(
    parameter int CREDITS  = 4,
    parameter int SB_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       core_issue_valid,
    output logic       core_issue_ready,
    input  logic       core_dispatch_valid,
    input  logic       core_dispatch_kill,
    output logic       vpu_issue_valid,
    output logic [4:0] vpu_issue_sb_id,
    input  logic       vpu_issue_credit,
    output logic       vpu_dispatch_valid,
    output logic       vpu_dispatch_next_senior,
    output logic       vpu_dispatch_kill,
    output logic [4:0] vpu_dispatch_sb_id,
    input  logic       vpu_completed_valid,
    input  logic [4:0] vpu_completed_sb_id,
    output logic       core_completed_valid,
    output logic [4:0] core_completed_sb_id,
    output logic [5:0] outstanding,
    output logic       err
);

    localparam int               c_PTR_W     = $clog2(SB_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH     = (c_PTR_W + 1)'(SB_DEPTH);
    localparam logic [3:0]       c_CREDITS   = 4'(CREDITS);
    localparam logic [1:0]       c_ST_FREE   = 2'd0;
    localparam logic [1:0]       c_ST_ISSUED = 2'd1;
    localparam logic [1:0]       c_ST_SENIOR = 2'd2;

    logic [1:0]         r_state [SB_DEPTH];
    logic [c_PTR_W:0]   r_head;
    logic [c_PTR_W:0]   r_tail;
    logic [c_PTR_W:0]   r_disp;
    logic [3:0]         r_credits;
    logic               r_err;
    logic               r_issue_valid;
    logic [4:0]         r_issue_id;
    logic               r_disp_valid;
    logic               r_disp_ns;
    logic               r_disp_kill;
    logic [4:0]         r_disp_id;
    logic               r_comp_valid;
    logic [4:0]         r_comp_id;

    logic [c_PTR_W:0]   w_occ;
    logic               w_full;
    logic [c_PTR_W-1:0] w_head_idx;
    logic [c_PTR_W-1:0] w_tail_idx;
    logic [c_PTR_W-1:0] w_disp_idx;
    logic [c_PTR_W-1:0] w_comp_idx;
    logic               w_issue_fire;
    logic               w_has_issued;
    logic               w_disp_fire;
    logic               w_disp_err;
    logic               w_comp_in_range;
    logic               w_comp_fire;
    logic               w_comp_err;
    logic               w_retire;
    logic               w_credit_err;

    assign w_occ       = r_tail - r_head;
    assign w_full      = (w_occ == c_DEPTH);
    assign w_head_idx  = r_head[c_PTR_W-1:0];
    assign w_tail_idx  = r_tail[c_PTR_W-1:0];
    assign w_disp_idx  = r_disp[c_PTR_W-1:0];
    assign w_comp_idx  = vpu_completed_sb_id[c_PTR_W-1:0];

    assign core_issue_ready = (r_credits != 4'd0) && !w_full;
    assign w_issue_fire     = core_issue_valid && core_issue_ready;

    // Every entry from the dispatch pointer up to the tail is still ISSUED.
    assign w_has_issued = (r_disp != r_tail);
    assign w_disp_fire  = core_dispatch_valid && w_has_issued;
    assign w_disp_err   = core_dispatch_valid && !w_has_issued;

    assign w_comp_in_range = ({1'b0, vpu_completed_sb_id} < 6'(SB_DEPTH));
    assign w_comp_fire     = vpu_completed_valid && w_comp_in_range
                             && (r_state[w_comp_idx] == c_ST_SENIOR);
    assign w_comp_err      = vpu_completed_valid && !w_comp_fire;

    assign w_retire     = (r_head != r_tail) && (r_state[w_head_idx] == c_ST_FREE);
    assign w_credit_err = vpu_issue_credit && !w_issue_fire && (r_credits == c_CREDITS);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_state[i] <= c_ST_FREE;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_disp        <= '0;
            r_credits     <= c_CREDITS;
            r_err         <= 1'b0;
            r_issue_valid <= 1'b0;
            r_issue_id    <= 5'd0;
            r_disp_valid  <= 1'b0;
            r_disp_ns     <= 1'b0;
            r_disp_kill   <= 1'b0;
            r_disp_id     <= 5'd0;
            r_comp_valid  <= 1'b0;
            r_comp_id     <= 5'd0;
        end else begin
            // Issue, dispatch and completion always target distinct entries
            // (FREE tail, ISSUED dispatch slot, SENIOR completion slot).
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (w_issue_fire && (w_tail_idx == c_PTR_W'(i))) begin
                    r_state[i] <= c_ST_ISSUED;
                end else if (w_disp_fire && (w_disp_idx == c_PTR_W'(i))) begin
                    r_state[i] <= core_dispatch_kill ? c_ST_FREE : c_ST_SENIOR;
                end else if (w_comp_fire && (w_comp_idx == c_PTR_W'(i))) begin
                    r_state[i] <= c_ST_FREE;
                end
            end

            if (w_issue_fire) r_tail <= r_tail + 1'b1;
            if (w_disp_fire)  r_disp <= r_disp + 1'b1;
            if (w_retire)     r_head <= r_head + 1'b1;

            case ({vpu_issue_credit, w_issue_fire})
                2'b10: if (r_credits != c_CREDITS) r_credits <= r_credits + 4'd1;
                2'b01: r_credits <= r_credits - 4'd1;
                default: ;
            endcase

            r_err <= r_err | w_credit_err | w_disp_err | w_comp_err;

            r_issue_valid <= w_issue_fire;
            if (w_issue_fire) r_issue_id <= 5'(w_tail_idx);

            r_disp_valid <= w_disp_fire;
            r_disp_ns    <= w_disp_fire && !core_dispatch_kill;
            r_disp_kill  <= w_disp_fire && core_dispatch_kill;
            if (w_disp_fire) r_disp_id <= 5'(w_disp_idx);

            r_comp_valid <= w_comp_fire;
            if (w_comp_fire) r_comp_id <= vpu_completed_sb_id;
        end
    end

    assign vpu_issue_valid          = r_issue_valid;
    assign vpu_issue_sb_id          = r_issue_id;
    assign vpu_dispatch_valid       = r_disp_valid;
    assign vpu_dispatch_next_senior = r_disp_ns;
    assign vpu_dispatch_kill        = r_disp_kill;
    assign vpu_dispatch_sb_id       = r_disp_id;
    assign core_completed_valid     = r_comp_valid;
    assign core_completed_sb_id     = r_comp_id;
    assign outstanding              = 6'(w_occ);
    assign err                      = r_err;

endmodule
`default_nettype wire
